// File: rtl/pwm_symbol_decoder.sv
// pwm_symbol_decoder: measures HI pulse widths on a thresholded sample stream and emits them as symbols.
// Define PWM_DEC_ROUNDING_EN to round the symbol half-up instead of truncating.
module pwm_symbol_decoder #(
  parameter int DATA_W    = 16,
  parameter int SYM_W     = 8,
  parameter int CNT_W     = 12,
  parameter int DIV_SHIFT = 2,
  parameter int MIN_PULSE = 3,
  parameter int MAX_PULSE = 2000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable_counter,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic        [DATA_W-2:0] hyst_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [SYM_W-1:0]  decoded_symbol,
  output logic                     symbol_valid,
  output logic                     symbol_err
);
  typedef enum logic [1:0] {IDLE, WAIT_LOW, ARMED, HIGH} state_t;
  localparam logic [CNT_W:0] SYM_MAX = (CNT_W+1)'((1 << (SYM_W-1)) - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic signed [SYM_W-1:0] sym_nx, sym_sat;
  logic valid_nx, err_nx, is_hi, is_lo;
  logic signed [DATA_W:0] data_x, hi_th, lo_th;
  logic [CNT_W:0] sum, quo;
  // One extra bit keeps ref +/- hyst from wrapping at the rails.
  assign data_x = {data_in[DATA_W-1], data_in};
  assign hi_th  = {ref_in[DATA_W-1], ref_in} + {2'b00, hyst_in};
  assign lo_th  = {ref_in[DATA_W-1], ref_in} - {2'b00, hyst_in};
  assign is_hi  = sample_valid && (data_x > hi_th);
  assign is_lo  = sample_valid && (data_x < lo_th);
`ifdef PWM_DEC_ROUNDING_EN
  localparam logic [CNT_W:0] HALF = (CNT_W+1)'((1 << DIV_SHIFT) >> 1);
  assign sum = {1'b0, count} + HALF;
`else
  assign sum = {1'b0, count};
`endif
  assign quo     = sum >> DIV_SHIFT;
  assign sym_sat = quo > SYM_MAX ? SYM_W'(SYM_MAX) : SYM_W'(quo);
  always_comb begin
    state_nx = state;
    count_nx = count;
    sym_nx   = decoded_symbol;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    if (!enable_counter) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE:     state_nx = WAIT_LOW;
        WAIT_LOW: state_nx = is_lo ? ARMED : WAIT_LOW;
        ARMED: if (is_hi) begin
          state_nx = HIGH;
          count_nx = CNT_W'(1);
        end
        HIGH: if (is_lo) begin
          state_nx = ARMED;
          count_nx = '0;
          err_nx   = count < CNT_W'(MIN_PULSE);
          valid_nx = !err_nx;
          sym_nx   = err_nx ? decoded_symbol : sym_sat;
        end else if (sample_valid) begin
          // A pulse that outgrows MAX_PULSE is dropped; a fresh LO is needed before re-arming.
          err_nx   = count >= CNT_W'(MAX_PULSE);
          state_nx = err_nx ? WAIT_LOW : HIGH;
          count_nx = err_nx ? '0 : count + CNT_W'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= '0;
      decoded_symbol <= '0;
      symbol_valid   <= 1'b0;
      symbol_err     <= 1'b0;
    end else begin
      state          <= state_nx;
      count          <= count_nx;
      decoded_symbol <= sym_nx;
      symbol_valid   <= valid_nx;
      symbol_err     <= err_nx;
    end
  end
endmodule

// File: tb/tb_pwm_symbol_decoder.sv
// tb_pwm_symbol_decoder: directed pulses with a queue of expected strobes checked by an independent monitor.
module tb_pwm_symbol_decoder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable_counter = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [15:0] ref_in = 16'sd95;
  logic [14:0] hyst_in = '0;
  logic signed [15:0] data_in = '0;
  logic signed [7:0] decoded_symbol;
  logic symbol_valid, symbol_err;

  typedef struct packed {logic err; logic [7:0] sym;} exp_t;
  exp_t sb[$];
  logic [7:0] last_sym = '0;
  int vectors = 0;
  int miscompares = 0;

  pwm_symbol_decoder dut (
    .clock(clock), .reset_n(reset_n), .enable_counter(enable_counter),
    .sample_valid(sample_valid), .ref_in(ref_in), .hyst_in(hyst_in), .data_in(data_in),
    .decoded_symbol(decoded_symbol), .symbol_valid(symbol_valid), .symbol_err(symbol_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_sym(input logic [7:0] trunc, input logic [7:0] rnd);
`ifdef PWM_DEC_ROUNDING_EN
    last_sym = rnd;
`else
    last_sym = trunc;
`endif
    sb.push_back('{err: 1'b0, sym: last_sym});
  endtask

  task automatic expect_err();
    sb.push_back('{err: 1'b1, sym: last_sym});
  endtask

  task automatic send(input logic signed [15:0] d);
    @(negedge clock);
    sample_valid = 1'b1;
    data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample_valid = 1'b0;
      data_in = -16'sd500;
    end
  endtask

  task automatic hi(input int n);
    for (int i = 0; i < n; i++) send(16'sd200);
  endtask

  task automatic lo();
    send(-16'sd84);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (symbol_valid && symbol_err) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_overlap: got valid=1 err=1, expected at most one");
    end else if (symbol_valid || symbol_err) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b sym=%0d, expected none",
                 symbol_valid, symbol_err, decoded_symbol);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind_err", {7'd0, symbol_err}, {7'd0, e.err});
        check("decoded_symbol", decoded_symbol, e.sym);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset_symbol", decoded_symbol, 8'd0);
    check("reset_valid", {7'd0, symbol_valid}, 8'd0);
    check("reset_err", {7'd0, symbol_err}, 8'd0);
    idle(2);
    reset_n = 1'b1;
    enable_counter = 1'b1;
    idle(2);
    send(16'sd0);
    for (int i = 0; i < 35; i++) send(16'sd100);
    expect_sym(8'd8, 8'd9);
    lo();
    idle(2);
    ref_in = 16'sd0;
    hyst_in = 15'd10;
    idle(1);
    send(16'sd50); send(16'sd50); send(16'sd5); send(-16'sd5); send(16'sd50);
    expect_sym(8'd1, 8'd1);
    send(-16'sd20);
    hi(2);
    expect_err();
    lo();
    hi(3);
    expect_sym(8'd0, 8'd1);
    lo();
    hi(2000);
    expect_sym(8'd127, 8'd127);
    lo();
    hi(2000);
    expect_err();
    hi(1);
    hi(5);
    lo();
    hi(8);
    expect_sym(8'd2, 8'd2);
    lo();
    for (int i = 0; i < 12; i++) begin
      send(16'sd200);
      idle(1);
    end
    expect_sym(8'd3, 8'd3);
    lo();
    hi(20);
    @(negedge clock);
    sample_valid = 1'b0;
    enable_counter = 1'b0;
    idle(1);
    enable_counter = 1'b1;
    idle(1);
    hi(10);
    lo();
    hi(4);
    expect_sym(8'd1, 8'd1);
    lo();
    hi(20);
    @(negedge clock);
    sample_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_symbol", decoded_symbol, 8'd0);
    check("async_reset_valid", {7'd0, symbol_valid}, 8'd0);
    last_sym = 8'd0;
    #2 reset_n = 1'b1;
    hi(10);
    lo();
    hi(4);
    expect_sym(8'd1, 8'd1);
    lo();
    idle(5);
    check("queue_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_symbol_decoder.md
PWM_SYMBOL_DECODER -- requirements
Module: pwm_symbol_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample and threshold width, signed.
REQ-002 SHALL have parameter SYM_W, default 8: symbol output width, signed.
REQ-003 SHALL have parameter CNT_W, default 12: pulse-width counter width, unsigned.
REQ-004 SHALL have parameter DIV_SHIFT, default 2: log2 of samples per symbol unit.
REQ-005 SHALL have parameter MIN_PULSE, default 3: shortest accepted pulse, in samples.
REQ-006 SHALL have parameter MAX_PULSE, default 2000: longest accepted pulse, in samples; MAX_PULSE < 2^CNT_W-1.
REQ-007 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port enable_counter, input, 1: decoder enable.
REQ-010 SHALL have port sample_valid, input, 1: data_in is valid this cycle.
REQ-011 SHALL have port ref_in, input, DATA_W signed: detection threshold.
REQ-012 SHALL have port hyst_in, input, DATA_W-1 unsigned: hysteresis half-width.
REQ-013 SHALL have port data_in, input, DATA_W signed: demodulated sample.
REQ-014 SHALL have port decoded_symbol, output, SYM_W signed: last decoded symbol (registered).
REQ-015 SHALL have port symbol_valid, output, 1: one-cycle strobe for a new decoded_symbol.
REQ-016 SHALL have port symbol_err, output, 1: one-cycle strobe for a rejected pulse.

Function
REQ-017 SHALL classify a valid sample as HI when data_in > ref_in+hyst_in, and as LO when data_in < ref_in-hyst_in; otherwise BAND; all compares use DATA_W+1-bit signed arithmetic, with no wrap.
REQ-018 SHALL run a 4-state FSM: IDLE, WAIT_LOW, ARMED, HIGH.
REQ-019 SHALL go IDLE->WAIT_LOW when enable_counter=1; WAIT_LOW->ARMED on a LO sample; ARMED->HIGH on a HI sample, loading count=1.
REQ-020 SHALL in HIGH, on each HI or BAND valid sample, increment count.
REQ-021 SHALL in HIGH, on a LO sample, end the pulse and return to ARMED.
REQ-022 SHALL ignore cycles with sample_valid=0: no state change, no count change.
REQ-023 SHALL, at pulse end with MIN_PULSE<=count<=MAX_PULSE, compute symbol=count>>DIV_SHIFT, saturate to 2^(SYM_W-1)-1, register it to decoded_symbol, and pulse symbol_valid.
REQ-024 SHALL, at pulse end with count<MIN_PULSE, pulse symbol_err, leave decoded_symbol unchanged, and keep symbol_valid=0.
REQ-025 SHALL, when count would exceed MAX_PULSE, pulse symbol_err, clear count, and go to WAIT_LOW with no symbol.
REQ-026 SHALL assert symbol_valid/symbol_err exactly one cycle after the clock edge that samples the terminating sample; the two are never asserted together.
REQ-027 SHALL, when enable_counter=0 in any state, go to IDLE next cycle, clear count, and emit no strobe; this takes priority over every other transition.
REQ-028 SHALL allow back-to-back pulses: a HI sample in ARMED on the cycle after a strobe starts a new count.

Reset
REQ-029 SHALL, on reset_n=0, immediately force state=IDLE, count=0, decoded_symbol=0, symbol_valid=0, symbol_err=0, independent of clock.
REQ-030 SHALL, on reset mid-pulse, discard the partial pulse and require a LO sample before the next measurement.

Configuration
REQ-031 SHALL, with macro PWM_DEC_ROUNDING_EN defined, compute symbol=(count+2^(DIV_SHIFT-1))>>DIV_SHIFT (round-half-up), using a CNT_W+1-bit intermediate before saturation.
REQ-032 SHALL, with PWM_DEC_ROUNDING_EN undefined, truncate per REQ-023.

Verification
REQ-033 SHALL cover: defaults, ref_in=95, hyst_in=0, data_in=0 then 35 samples >95, then -84 -> rounding: decoded_symbol=9 with symbol_valid 1 cycle after the -84 edge; truncation: 8.
REQ-034 SHALL cover: hyst_in=10, ref_in=0, samples 50,50,5,-5,50,-20 -> one pulse of count 5 (the BAND samples are counted), then symbol 1 (truncation) or 1 (rounding).
REQ-035 SHALL cover: a 2-sample HI pulse -> symbol_err pulse, and decoded_symbol holds its prior value.
REQ-036 SHALL cover: a 2001-sample HI run -> symbol_err on the sample that would give count 2001, then the FSM waits for LO before measuring again.
REQ-037 SHALL cover: enable_counter dropped at count 20, or reset_n pulsed at count 20 -> no strobe, and a pulse starting HI after re-enable is not measured until a LO sample is seen.
REQ-038 SHALL cover: sample_valid toggling 1/0 during a 12-sample pulse -> count 12, unaffected by the invalid cycles.
